icache_refill: RTL
==================

ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_LENGTH, 32, address width in instruction (32-bit word) units.
- MMU_WRITE_LENGTH, 32, data word width.
- WRITE_LINE_SIZE, 8192, cache line size in bits.
- MAX_OUTSTANDING, 4, maximum granted but unanswered memory reads.
- Derived: WORDS = WRITE_LINE_SIZE/MMU_WRITE_LENGTH (256); OFS = $clog2(WORDS) (8).

REQ-002 Ports (name, direction, width, meaning):
- i_clk  in  1  single clock; all state on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_miss  in  1  miss request from the cache controller, level.
- i_miss_addr  in  ADDR_LENGTH  missing instruction address.
- o_busy  out  1  refill in progress.
- o_done  out  1  one-cycle pulse, line fully written.
- o_err  out  1  one-cycle pulse, refill aborted.
- o_mmu_we  out  1  write strobe into the cache.
- o_mmu_data  out  MMU_WRITE_LENGTH  word to write.
- o_mmu_addr  out  ADDR_LENGTH  address of o_mmu_data.
- o_mem_req  out  1  read request to memory.
- o_mem_addr  out  ADDR_LENGTH  read address.
- i_mem_gnt  in  1  request accepted this cycle.
- i_mem_rvalid  in  1  read response valid; responses arrive in request order.
- i_mem_rdata  in  MMU_WRITE_LENGTH  response data.
- i_mem_err  in  1  response error, qualified by i_mem_rvalid.

Function
REQ-003 FSM states: IDLE, FILL, DRAIN, DONE.
REQ-004 IDLE: when i_miss=1, latch line base (i_miss_addr with low OFS bits cleared) and start offset (low OFS bits), then go to FILL; i_miss and i_miss_addr are ignored in every other state.
REQ-005 Issue order is critical-word-first: request k uses offset (start+k) mod WORDS, so the address wraps within the line and never carries into the base.
REQ-006 o_mem_req shall be 1 in FILL while issued<WORDS and outstanding<MAX_OUTSTANDING; a handshake occurs when o_mem_req & i_mem_gnt.
REQ-007 o_mem_addr shall be held stable until the grant, and the next address may be presented on the cycle after it.
REQ-008 Outstanding counter: +1 on handshake, -1 on i_mem_rvalid, unchanged when both occur in one cycle, never exceeds MAX_OUTSTANDING.
REQ-009 For each response with i_mem_err=0, the block shall drive o_mmu_we=1 one cycle later (registered), with o_mmu_data = rdata and o_mmu_addr = base | offset of the matching request.
REQ-010 FILL to DONE when the WORDS-th good response is received.
REQ-011 DONE lasts exactly one cycle: o_done=1 that cycle, then IDLE; the cache must drop i_miss by then.
REQ-012 Response with i_mem_err=1 in FILL: that word is not written; no further requests; go to DRAIN.
REQ-013 DRAIN: discard all remaining responses without writing; when outstanding reaches 0, pulse o_err for one cycle and go to IDLE; o_done is not asserted.
REQ-014 o_busy shall be 1 in FILL, DRAIN and DONE.
REQ-015 A cycle with i_mem_rvalid=1 while outstanding=0 shall be ignored, with no write and no counter change.
REQ-016 Latency: i_miss sampled at cycle t gives o_mem_req=1 at t+1; with single-cycle memory, o_done fires no later than t+WORDS+3.

Reset
REQ-017 Asserting i_rst shall immediately force IDLE, zero all counters, and drive every output to 0, including when asserted mid-refill.
REQ-018 After reset, no write from a pre-reset request shall ever be issued; late responses are handled as in REQ-015.

Structure
REQ-019 Package icache_pkg shall hold the state enum and the default values of ADDR_LENGTH, MMU_WRITE_LENGTH and WRITE_LINE_SIZE, shared with the cache controller.
REQ-020 The design shall be a single flat module with no sub-module: a small FSM plus issue, response and outstanding counters.

Verification (defaults)
REQ-021 Reset held, random inputs -> all outputs 0, o_busy=0.
REQ-022 Miss at 0x0000_1234 with gnt=1 and rvalid one cycle after grant -> 256 writes with addresses 0x1234..0x12FF then 0x1200..0x1233, each data matching, exactly one o_done, no o_err.
REQ-023 i_mem_gnt=0 for 10 cycles -> o_mem_req stays 1 with o_mem_addr=0x1234 stable, and no writes occur.
REQ-024 gnt=1 with no rvalid for 20 cycles -> exactly 4 handshakes, then o_mem_req=0 until a response arrives.
REQ-025 Error on the 5th response with 4 outstanding -> exactly 4 writes, remaining responses discarded, one o_err pulse once outstanding=0, no o_done.
REQ-026 i_rst asserted after 100 writes, with 3 stale rvalids afterwards -> outputs 0 immediately, no further writes, and a new miss at 0x0000_0000 completes normally.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: refill state encoding and default cache geometry shared with the cache controller
package icache_pkg;
  localparam int ICACHE_ADDR_LENGTH      = 32;
  localparam int ICACHE_MMU_WRITE_LENGTH = 32;
  localparam int ICACHE_WRITE_LINE_SIZE  = 8192;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} refill_state_e;
endpackage

// File: rtl/icache_refill.sv
// icache_refill: critical-word-first line refill with bounded outstanding memory reads
module icache_refill
  import icache_pkg::*;
#(
  parameter int ADDR_LENGTH      = ICACHE_ADDR_LENGTH,
  parameter int MMU_WRITE_LENGTH = ICACHE_MMU_WRITE_LENGTH,
  parameter int WRITE_LINE_SIZE  = ICACHE_WRITE_LINE_SIZE,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_miss,
  input  logic [ADDR_LENGTH-1:0]      i_miss_addr,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err,
  output logic                        o_mmu_we,
  output logic [MMU_WRITE_LENGTH-1:0] o_mmu_data,
  output logic [ADDR_LENGTH-1:0]      o_mmu_addr,
  output logic                        o_mem_req,
  output logic [ADDR_LENGTH-1:0]      o_mem_addr,
  input  logic                        i_mem_gnt,
  input  logic                        i_mem_rvalid,
  input  logic [MMU_WRITE_LENGTH-1:0] i_mem_rdata,
  input  logic                        i_mem_err
);
  localparam int WORDS = WRITE_LINE_SIZE / MMU_WRITE_LENGTH;
  localparam int OFS   = $clog2(WORDS);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  refill_state_e               state_q, state_d;
  logic [ADDR_LENGTH-1:0]      base_q, base_d, waddr_q, waddr_d;
  logic [OFS-1:0]              start_q, start_d, iss_ofs, rsp_ofs;
  logic [OFS:0]                issued_q, issued_d, good_q, good_d;
  logic [OW-1:0]               outst_q, outst_d;
  logic [MMU_WRITE_LENGTH-1:0] wdata_q, wdata_d;
  logic                        we_q, launch, hs, rsp, wr, last;
  // offsets wrap inside the line so the base is never disturbed
  assign iss_ofs = start_q + issued_q[OFS-1:0];
  assign rsp_ofs = start_q + good_q[OFS-1:0];
  assign launch  = state_q == S_IDLE && i_miss;
  assign hs      = o_mem_req && i_mem_gnt;
  // responses with nothing outstanding are stale (e.g. from before a reset) and ignored
  assign rsp     = i_mem_rvalid && outst_q != '0 && (state_q == S_FILL || state_q == S_DRAIN);
  assign wr      = rsp && state_q == S_FILL && !i_mem_err;
  assign last    = wr && good_q == (OFS+1)'(WORDS - 1);
  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end
  // next-state: an error response aborts into DRAIN, the final good word completes
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = i_miss ? S_FILL : S_IDLE;
      S_FILL:  state_d = rsp && i_mem_err ? S_DRAIN : last ? S_DONE : S_FILL;
      S_DRAIN: state_d = outst_q == '0 ? S_IDLE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end
  // outputs decoded from state and counters; address stays put until granted
  always_comb begin
    o_busy     = state_q != S_IDLE;
    o_done     = state_q == S_DONE;
    o_err      = state_q == S_DRAIN && outst_q == '0;
    o_mem_req  = state_q == S_FILL && issued_q < (OFS+1)'(WORDS) && outst_q < OW'(MAX_OUTSTANDING);
    o_mem_addr = base_q | ADDR_LENGTH'(iss_ofs);
    o_mmu_we   = we_q;
    o_mmu_data = wdata_q;
    o_mmu_addr = waddr_q;
  end
  // counter and write-port next values
  always_comb begin
    base_d   = launch ? {i_miss_addr[ADDR_LENGTH-1:OFS], OFS'(0)} : base_q;
    start_d  = launch ? i_miss_addr[OFS-1:0] : start_q;
    issued_d = launch ? '0 : issued_q + (OFS+1)'(hs);
    good_d   = launch ? '0 : good_q + (OFS+1)'(wr);
    outst_d  = outst_q + OW'(hs) - OW'(rsp);
    waddr_d  = wr ? base_q | ADDR_LENGTH'(rsp_ofs) : waddr_q;
    wdata_d  = wr ? i_mem_rdata : wdata_q;
  end
  // datapath registers, all cleared by reset so no pre-reset write can escape
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      base_q   <= '0;
      start_q  <= '0;
      issued_q <= '0;
      good_q   <= '0;
      outst_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      base_q   <= base_d;
      start_q  <= start_d;
      issued_q <= issued_d;
      good_q   <= good_d;
      outst_q  <= outst_d;
      we_q     <= wr;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end
endmodule
